// File: rtl/output_bias_loader_pkg.sv
// Shared sizing and state encoding for the output-layer bias path.
// Also imported by the output-layer control.
package output_bias_loader_pkg;

    localparam int N_OUT  = 10;
    localparam int DATA_W = 8;
    localparam int SUM_W  = 12;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } bias_state_e;

    function automatic logic [SUM_W-1:0] sext_bias(input logic [DATA_W-1:0] b);
        return {{(SUM_W-DATA_W){b[DATA_W-1]}}, b};
    endfunction

endpackage

// File: rtl/output_bias_loader_if.sv
// Byte-stream handshake into the bias loader, plus the frame start pulse.
interface output_bias_loader_if;
    import output_bias_loader_pkg::*;

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output start, output in_valid, output in_data, input in_ready);
    modport slave  (input start, input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/output_bias_loader_bias_reg_bank.sv
// Ten-entry bias register bank with a single write port and synchronous clear.
module bias_reg_bank
    import output_bias_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] res_o [N_OUT]
);

    logic [DATA_W-1:0] res_q [N_OUT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                res_q[i] <= '0;
            end
        end else if (we_i && (waddr_i < IDX_W'(N_OUT))) begin
            res_q[waddr_i] <= wdata_i;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/output_bias_loader.sv
// Loads ten signed bias bytes in order into the bias bank and keeps a
// running checksum of the current frame.
//
// state   | meaning
// IDLE    | after reset, waiting for the first start
// LOAD    | accepting bytes, in_ready high
// DONE    | all ten entries written, waiting for a new start
module output_bias_loader
    import output_bias_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output_bias_loader_if.slave  bus,
    output logic [DATA_W-1:0]    res0,
    output logic [DATA_W-1:0]    res1,
    output logic [DATA_W-1:0]    res2,
    output logic [DATA_W-1:0]    res3,
    output logic [DATA_W-1:0]    res4,
    output logic [DATA_W-1:0]    res5,
    output logic [DATA_W-1:0]    res6,
    output logic [DATA_W-1:0]    res7,
    output logic [DATA_W-1:0]    res8,
    output logic [DATA_W-1:0]    res9,
    output logic                 loaded,
    output logic                 busy,
    output logic [SUM_W-1:0]     bias_sum
);

    bias_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              loaded_q, loaded_d;
    logic              we;
    logic [DATA_W-1:0] res [N_OUT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sum_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            loaded_q <= loaded_d;
        end
    end

    // start always wins over a same-cycle byte so a restart drops it
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        loaded_d = loaded_q;
        we       = 1'b0;
        if (bus.start) begin
            state_d  = ST_LOAD;
            idx_d    = '0;
            sum_d    = '0;
            loaded_d = 1'b0;
        end else if (state_q == ST_LOAD && bus.in_valid) begin
            we    = 1'b1;
            sum_d = sum_q + sext_bias(bus.in_data);
            if (idx_q == IDX_W'(N_OUT - 1)) begin
                state_d  = ST_DONE;
                idx_d    = '0;
                loaded_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    bias_reg_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (idx_q),
        .wdata_i (bus.in_data),
        .res_o   (res)
    );

    assign busy         = (state_q == ST_LOAD);
    assign bus.in_ready = busy;
    assign loaded       = loaded_q;
    assign bias_sum     = sum_q;

    assign res0 = res[0];
    assign res1 = res[1];
    assign res2 = res[2];
    assign res3 = res[3];
    assign res4 = res[4];
    assign res5 = res[5];
    assign res6 = res[6];
    assign res7 = res[7];
    assign res8 = res[8];
    assign res9 = res[9];

endmodule

// File: tb/tb_output_bias_loader.sv
// Directed test-plan scenarios plus random traffic against a frame-level model.
module tb_output_bias_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  res0, res1, res2, res3, res4, res5, res6, res7, res8, res9;
    logic        loaded, busy;
    logic [11:0] bias_sum;
    logic [7:0]  res_a [10];

    int n_chk;
    int n_fail;

    // model: frame mode, count of bytes written, entries, sum
    int          m_mode;
    int          m_cnt;
    int          m_sum;
    logic [7:0]  m_res [10];

    output_bias_loader_if bus();

    output_bias_loader dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .res0     (res0), .res1(res1), .res2(res2), .res3(res3), .res4(res4),
        .res5     (res5), .res6(res6), .res7(res7), .res8(res8), .res9(res9),
        .loaded   (loaded),
        .busy     (busy),
        .bias_sum (bias_sum)
    );

    assign res_a[0] = res0; assign res_a[1] = res1; assign res_a[2] = res2;
    assign res_a[3] = res3; assign res_a[4] = res4; assign res_a[5] = res5;
    assign res_a[6] = res6; assign res_a[7] = res7; assign res_a[8] = res8;
    assign res_a[9] = res9;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_sum  = 0;
        for (int i = 0; i < 10; i++) m_res[i] = 8'h00;
    endtask

    task automatic check_all();
        chk("busy", {31'b0, busy}, {31'b0, m_mode == 1});
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_mode == 1});
        chk("loaded", {31'b0, loaded}, {31'b0, m_mode == 2});
        chk("bias_sum", {20'b0, bias_sum}, m_sum & 32'hFFF);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("res%0d", i), {24'b0, res_a[i]}, {24'b0, m_res[i]});
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d);
        rst          = r;
        bus.start    = s;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (s) begin
            m_mode = 1;
            m_cnt  = 0;
            m_sum  = 0;
        end else if (m_mode == 1 && v) begin
            m_res[m_cnt] = d;
            m_sum        = m_sum + int'($signed(d));
            m_cnt++;
            if (m_cnt == 10) m_mode = 2;
        end
        #1;
        check_all();
    endtask

    task automatic load_frame(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, d);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;

        // reset with in_valid high
        step(1'b1, 1'b0, 1'b1, 8'h5A);
        step(1'b1, 1'b1, 1'b1, 8'h33);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sum", {20'b0, bias_sum}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h44);

        // back-to-back 1..10
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
        chk("b2b_sum", {20'b0, bias_sum}, 32'd55);
        chk("b2b_loaded", {31'b0, loaded}, 32'd1);
        chk("b2b_res0", {24'b0, res0}, 32'd1);
        chk("b2b_res9", {24'b0, res9}, 32'd10);
        step(1'b0, 1'b0, 1'b1, 8'h77);
        chk("b2b_ready", {31'b0, bus.in_ready}, 32'd0);

        // gapped stream
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'hEE);
            step(1'b0, 1'b0, 1'b1, 8'(i));
        end
        chk("gap_sum", {20'b0, bias_sum}, 32'd55);
        chk("gap_res4", {24'b0, res4}, 32'd5);

        // negative and positive extremes
        step(1'b0, 1'b1, 1'b0, 8'h00);
        load_frame(8'h80, 10);
        chk("neg_sum", {20'b0, bias_sum}, 32'hB00);
        chk("neg_res7", {24'b0, res7}, 32'h80);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        load_frame(8'h7F, 10);
        chk("pos_sum", {20'b0, bias_sum}, 32'h4F6);

        // restart mid-frame drops the coincident byte
        step(1'b0, 1'b1, 1'b0, 8'h00);
        load_frame(8'hAA, 4);
        step(1'b0, 1'b1, 1'b1, 8'hAA);
        chk("rs_sum0", {20'b0, bias_sum}, 32'd0);
        load_frame(8'h01, 10);
        chk("rs_sum", {20'b0, bias_sum}, 32'd10);
        chk("rs_res3", {24'b0, res3}, 32'd1);

        // reset mid-frame
        step(1'b0, 1'b1, 1'b0, 8'h00);
        load_frame(8'h23, 6);
        step(1'b1, 1'b0, 1'b1, 8'h23);
        chk("mr_res0", {24'b0, res0}, 32'd0);
        load_frame(8'h19, 3);
        chk("mr_sum", {20'b0, bias_sum}, 32'd0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(1) == 1), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/output_bias_loader.md
# output_bias_loader

Writer side of the output-layer bias store. It accepts a stream of signed 8-bit bias bytes over a valid/ready handshake and writes them in order into a 10-entry register bank. The bank is presented in parallel as `res0`..`res9`, the same shape the output layer consumes from the fixed bias memory. It also keeps a running signed checksum, so the host can confirm the load before the output layer is enabled.

## Interface
Parameters:
- `N_OUT`, 10, number of bias entries (output neurons); the port list is fixed at 10.
- `DATA_W`, 8, bias width in bits, two's complement.
- `SUM_W`, 12, checksum width in bits.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a new load frame.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  8  bias byte, signed.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `res0`..`res9`  out  8 each  registered bias entries.
- `loaded`  out  1  all 10 entries written in the current frame.
- `busy`  out  1  in state LOAD.
- `bias_sum`  out  12  signed sum of the bytes accepted in the current frame.

## Operation
- FSM states are IDLE, LOAD and DONE. Reset enters IDLE.
- IDLE → LOAD on `start`.
- LOAD → DONE on the 10th accepted byte.
- DONE → LOAD on `start`.
- In LOAD, `start` restarts the frame:
  - index returns to 0;
  - `bias_sum` returns to 0;
  - any byte handshaking in that same cycle is discarded.
- A handshake is `in_valid && in_ready`. `in_ready` equals `busy`, i.e. it is 1 only in LOAD.
- Each accepted byte writes `res[idx]`, where `idx` is a 4-bit counter running 0..9 that resets to 0 on `start`.
- Each accepted byte also updates `bias_sum` by adding `in_data`, sign-extended to 12 bits. The range ±1280 cannot overflow.
- On `start`:
  - `loaded` clears;
  - the `res` entries retain their old values until they are overwritten;
  - `bias_sum` clears to 0.
- `in_valid` outside LOAD is ignored, with no side effects.
- Reset values:
  - `res0`..`res9` = 0;
  - `bias_sum` = 0;
  - `loaded` = 0;
  - `busy` = 0;
  - `in_ready` = 0;
  - `idx` = 0.
- `rst` has priority over every other input, including `start` in the same cycle.

## Timing
- All outputs are registered; none has a combinational path from an input. `in_ready` is decoded from the state register.
- `start` at edge N gives `busy` = `in_ready` = 1 from N+1.
- A byte accepted at edge N is visible on `res[idx]` and in `bias_sum` from N+1.
- The 10th handshake at edge N gives, from N+1:
  - `loaded` = 1;
  - `busy` = 0;
  - `in_ready` = 0;
  - final `bias_sum`.
- Throughput is 1 byte/cycle. A full frame takes 10 cycles of handshakes plus 1 cycle for the `start` → LOAD transition.
- `in_valid` gaps stall the load indefinitely. There is no timeout.
- A reset mid-frame zeroes everything at the next edge. The partial frame is lost.

## Structure
- A shared package holds:
  - `N_OUT`, `DATA_W` and `SUM_W`;
  - the state encoding, 2 bits: IDLE=0, LOAD=1, DONE=2.
- This package is also used by the output-layer control.
- One sub-module, `bias_reg_bank`. It contains 10 × 8 registers with a write enable and a 4-bit write address, plus synchronous clear on `rst`.
- The FSM, the index counter and the checksum stay in the top module.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid`=1 → all `res` = 0, `bias_sum` = 0, and `loaded`, `busy`, `in_ready` all 0.
- **Back-to-back load:** `start`, then bytes 1..10 on consecutive cycles → `res0`=1 … `res9`=10; `loaded`=1 exactly one cycle after the 10th handshake; `bias_sum`=55; `in_ready`=0 afterwards.
- **Gapped stream:** same bytes with `in_valid` low on alternate cycles → identical `res` values and `bias_sum`=55; `idx` advances only on handshakes.
- **Negative extremes:** 10 × 8'h80 → every `res` = 8'h80 and `bias_sum` = 12'hB00 (−1280). Then a new frame of 10 × 8'h7F → `bias_sum` = 12'h4F6 (1270).
- **Restart mid-frame:** after 4 bytes (8'hAA), pulse `start` while a byte handshakes → that byte is dropped. Then 10 bytes of 8'h01 → all `res` = 1 and `bias_sum` = 10.
- **Reset mid-frame:** `rst` after 6 bytes → all outputs are at their reset values next cycle; `in_data` arriving afterwards is ignored until `start`.
